// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller.
// No logic, no latency: state codes, coin values and credit-width helpers.
// Backpressure: not applicable.
package vend_pkg;

  localparam int CREDIT_W  = 7;
  localparam int NICKEL_C  = 5;
  localparam int DIME_C    = 10;
  localparam int QUARTER_C = 25;

  // Codes are exported to the LED decoder, so the values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CREDIT   = 3'd1,
    ST_READY    = 3'd2,
    ST_DISPENSE = 3'd3,
    ST_CHANGE   = 3'd4,
    ST_REFUND   = 3'd5
  } vend_state_t;

  // Resting state implied by a credit value when no transaction is running.
  function automatic vend_state_t credit_state(input logic [CREDIT_W-1:0] c,
                                               input logic [CREDIT_W-1:0] price);
    if (c == '0) begin
      return ST_IDLE;
    end else if (c < price) begin
      return ST_CREDIT;
    end else begin
      return ST_READY;
    end
  endfunction

endpackage

// File: rtl/vend_pulse_timer.sv
// Loadable down-counter with a done flag; shared by dispense hold and change gap.
// Latency: load takes effect on the next cycle; done is high while the count is zero.
// Backpressure: none; a load always overrides the running count.
module vend_pulse_timer #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] count_q;

  // Count down to zero and park there until reloaded.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/vend_sequencer.sv
// Vending transaction controller: credit accounting, purchase, dispense and nickel return.
// Latency: every output is registered and reflects an input pulse one cycle later.
// Backpressure: none; coins that cannot be taken are refused via coin_reject.
// Build option: define VEND_CHANGE_RETURN_EN to return leftover credit after a dispense.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int PRICE_CENTS     = 75,
  parameter int MAX_CREDIT      = 95,
  parameter int DISPENSE_CYCLES = 4,
  parameter int CHANGE_GAP      = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_nickel,
  input  logic                coin_dime,
  input  logic                coin_quarter,
  input  logic                btn_select,
  input  logic                btn_cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic [2:0]          state,
  output logic                purchase_ready,
  output logic                dispense,
  output logic                change_nickel,
  output logic                coin_reject,
  output logic                busy
);

  localparam int TMR_MAX = (DISPENSE_CYCLES > CHANGE_GAP) ? DISPENSE_CYCLES : CHANGE_GAP;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [CREDIT_W-1:0] PRICE_V   = CREDIT_W'(PRICE_CENTS);
  localparam logic [CREDIT_W:0]   MAX_V     = (CREDIT_W + 1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] NICKEL_V  = CREDIT_W'(NICKEL_C);
  localparam logic [CREDIT_W-1:0] DIME_V    = CREDIT_W'(DIME_C);
  localparam logic [CREDIT_W-1:0] QUARTER_V = CREDIT_W'(QUARTER_C);
  localparam logic [TMR_W-1:0]    DISP_LD   = TMR_W'(DISPENSE_CYCLES - 1);
  localparam logic [TMR_W-1:0]    GAP_LD    = TMR_W'(CHANGE_GAP - 1);

  vend_state_t         state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                ready_q, ready_d;
  logic                dispense_q, dispense_d;
  logic                nickel_q, nickel_d;
  logic                reject_q, reject_d;
  logic                busy_q, busy_d;

  logic                tmr_load;
  logic [TMR_W-1:0]    tmr_val;
  logic                tmr_done;

  logic                coin_any;
  logic [1:0]          coin_cnt;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fits;

  // One timer serves both the dispense hold and the inter-nickel gap; they never overlap.
  vend_pulse_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .done_o    (tmr_done)
  );

  // Coin priority and overflow test: the highest-value coin wins, the rest are refused.
  always_comb begin
    coin_any = coin_nickel | coin_dime | coin_quarter;
    coin_cnt = 2'(coin_nickel) + 2'(coin_dime) + 2'(coin_quarter);
    if (coin_quarter) begin
      coin_val = QUARTER_V;
    end else if (coin_dime) begin
      coin_val = DIME_V;
    end else if (coin_nickel) begin
      coin_val = NICKEL_V;
    end else begin
      coin_val = '0;
    end
    coin_sum  = {1'b0, credit_q} + {1'b0, coin_val};
    coin_fits = (coin_sum <= MAX_V);
  end

  // Next-state and next-output decision for the transaction sequencer.
  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    dispense_d = 1'b0;
    nickel_d   = 1'b0;
    reject_d   = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;

    case (state_q)
      ST_IDLE, ST_CREDIT, ST_READY: begin
        if (btn_cancel && (state_q != ST_IDLE)) begin
          // Refund starts immediately: the first nickel leaves on the next cycle.
          state_d  = ST_REFUND;
          credit_d = credit_q - NICKEL_V;
          nickel_d = 1'b1;
          reject_d = coin_any;
        end else if (btn_select && (state_q == ST_READY)) begin
          // A coin arriving with the purchase is refused to keep the accounting simple.
          state_d    = ST_DISPENSE;
          credit_d   = credit_q - PRICE_V;
          dispense_d = 1'b1;
          tmr_load   = 1'b1;
          tmr_val    = DISP_LD;
          reject_d   = coin_any;
        end else if (coin_any) begin
          reject_d = (coin_cnt > 2'd1) || !coin_fits;
          if (coin_fits) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = credit_state(coin_sum[CREDIT_W-1:0], PRICE_V);
          end
        end
      end

      ST_DISPENSE: begin
        reject_d = coin_any;
        if (tmr_done) begin
`ifdef VEND_CHANGE_RETURN_EN
          if (credit_q != '0) begin
            // Change starts on the first cycle dispense is low.
            state_d  = ST_CHANGE;
            credit_d = credit_q - NICKEL_V;
            nickel_d = 1'b1;
          end else begin
            state_d = credit_state(credit_q, PRICE_V);
          end
`else
          state_d = credit_state(credit_q, PRICE_V);
`endif
        end else begin
          dispense_d = 1'b1;
        end
      end

`ifdef VEND_CHANGE_RETURN_EN
      ST_CHANGE, ST_REFUND: begin
`else
      ST_REFUND: begin
`endif
        reject_d = coin_any;
        if (nickel_q) begin
          // A pulse just went out: finish if nothing is left, else start the gap.
          if (credit_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = GAP_LD;
          end
        end else if (tmr_done && (credit_q != '0)) begin
          nickel_d = 1'b1;
          credit_d = credit_q - NICKEL_V;
        end
      end

      default: begin
        // Unused codes recover to a clean idle.
        state_d  = ST_IDLE;
        credit_d = '0;
        reject_d = coin_any;
      end
    endcase

    busy_d  = (state_d == ST_DISPENSE) || (state_d == ST_CHANGE) || (state_d == ST_REFUND);
    ready_d = (state_d == ST_READY);
  end

  // State and all outputs are registered together; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      credit_q   <= '0;
      ready_q    <= 1'b0;
      dispense_q <= 1'b0;
      nickel_q   <= 1'b0;
      reject_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      ready_q    <= ready_d;
      dispense_q <= dispense_d;
      nickel_q   <= nickel_d;
      reject_q   <= reject_d;
      busy_q     <= busy_d;
    end
  end

  assign credit         = credit_q;
  assign state          = state_q;
  assign purchase_ready = ready_q;
  assign dispense       = dispense_q;
  assign change_nickel  = nickel_q;
  assign coin_reject    = reject_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer: vector table, directed corner sequences,
// and randomized pulses compared each cycle against a credit-level reference model.
module tb_vend_sequencer;

  localparam int PRICE = 75;
  localparam int MAXC  = 95;
  localparam int DCYC  = 4;
  localparam int GAP   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_nickel = 1'b0, coin_dime = 1'b0, coin_quarter = 1'b0;
  logic       btn_select = 1'b0, btn_cancel = 1'b0;
  logic [6:0] credit;
  logic [2:0] state;
  logic       purchase_ready, dispense, change_nickel, coin_reject, busy;

  int total = 0;
  int bad   = 0;

  vend_sequencer #(
    .PRICE_CENTS(PRICE), .MAX_CREDIT(MAXC), .DISPENSE_CYCLES(DCYC), .CHANGE_GAP(GAP)
  ) dut (
    .clk(clk), .rst(rst),
    .coin_nickel(coin_nickel), .coin_dime(coin_dime), .coin_quarter(coin_quarter),
    .btn_select(btn_select), .btn_cancel(btn_cancel),
    .credit(credit), .state(state), .purchase_ready(purchase_ready),
    .dispense(dispense), .change_nickel(change_nickel), .coin_reject(coin_reject),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse(input logic n, input logic d, input logic q, input logic s, input logic c);
    coin_nickel = n; coin_dime = d; coin_quarter = q; btn_select = s; btn_cancel = c;
    tick();
    coin_nickel = 0; coin_dime = 0; coin_quarter = 0; btn_select = 0; btn_cancel = 0;
  endtask

  function automatic int outs();
    return int'({credit, state, purchase_ready, dispense, change_nickel, coin_reject, busy});
  endfunction

  // Cancel (if anything is held) and wait, bounded, for IDLE.
  task automatic drain(input string nm);
    if (state != 3'd0) pulse(0, 0, 0, 0, 1);
    for (int i = 0; i < 100 && state != 3'd0; i++) tick();
    chk(nm, {25'd0, state, credit}, 0);
  endtask

  // Observe 40 cycles starting now; record dispense length and nickel timing.
  task automatic scan(output int dcnt, output int ncnt, output int first_n, output int gap_ok);
    int prev_n;
    dcnt = 0; ncnt = 0; first_n = -1; gap_ok = 1; prev_n = -1;
    for (int i = 0; i < 40; i++) begin
      if (dispense) dcnt++;
      if (change_nickel) begin
        if (first_n < 0) first_n = i;
        else if (i - prev_n != 1 + GAP) gap_ok = 0;
        prev_n = i;
        ncnt++;
      end
      tick();
    end
  endtask

  // ---------------- reference model: credit in cents plus phase counters ----------------
  int m_state, m_credit, m_disp_left, m_gap_left;
  logic e_disp, e_nick, e_rej;

  function automatic int rest_code(input int c);
    if (c == 0) return 0;
    if (c < PRICE) return 1;
    return 2;
  endfunction

  task automatic model_step(input logic r, input logic n, input logic d, input logic q,
                            input logic s, input logic c);
    int coins, val;
    coins = int'(n) + int'(d) + int'(q);
    val = q ? 25 : (d ? 10 : (n ? 5 : 0));
    e_disp = 0; e_nick = 0; e_rej = 0;
    if (r) begin
      m_state = 0; m_credit = 0; m_disp_left = 0; m_gap_left = 0;
    end else if (m_state <= 2) begin
      if (c && m_state != 0) begin
        m_state = 5; m_credit -= 5; e_nick = 1; m_gap_left = GAP; e_rej = (coins > 0);
      end else if (s && m_state == 2) begin
        m_state = 3; m_credit -= PRICE; m_disp_left = DCYC; e_disp = 1; e_rej = (coins > 0);
      end else if (coins > 0) begin
        if (m_credit + val <= MAXC) begin
          m_credit += val; m_state = rest_code(m_credit); e_rej = (coins > 1);
        end else begin
          e_rej = 1;
        end
      end
    end else if (m_state == 3) begin
      e_rej = (coins > 0);
      m_disp_left--;
      if (m_disp_left > 0) begin
        e_disp = 1;
      end else begin
`ifdef VEND_CHANGE_RETURN_EN
        if (m_credit > 0) begin
          m_state = 4; m_credit -= 5; e_nick = 1; m_gap_left = GAP;
        end else m_state = rest_code(m_credit);
`else
        m_state = rest_code(m_credit);
`endif
      end
    end else begin
      e_rej = (coins > 0);
      if (m_credit == 0) m_state = 0;
      else if (m_gap_left > 0) m_gap_left--;
      else begin
        m_credit -= 5; e_nick = 1; m_gap_left = GAP;
      end
    end
  endtask

  function automatic int model_outs();
    logic [6:0] c7;
    logic [2:0] s3;
    c7 = 7'(m_credit);
    s3 = 3'(m_state);
    return int'({c7, s3, (m_state == 2) ? 1'b1 : 1'b0, e_disp, e_nick, e_rej,
                 (m_state >= 3) ? 1'b1 : 1'b0});
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic n, d, q, s, c;
    int   credit;
    int   st;
    logic rdy;
    logic rej;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int dcnt, ncnt, first_n, gap_ok;
    logic rn, rd, rq, rs, rc, rr;

    tbl[0]  = '{0, 0, 1, 0, 0, 25, 1, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 25, 1, 0, 0};
    tbl[2]  = '{1, 1, 0, 0, 0, 35, 1, 0, 1};
    tbl[3]  = '{1, 1, 1, 0, 0, 60, 1, 0, 1};
    tbl[4]  = '{0, 0, 0, 1, 0, 60, 1, 0, 0};
    tbl[5]  = '{1, 0, 0, 0, 0, 65, 1, 0, 0};
    tbl[6]  = '{0, 1, 0, 0, 0, 75, 2, 1, 0};
    tbl[7]  = '{0, 0, 1, 0, 0, 75, 2, 1, 1};
    tbl[8]  = '{0, 1, 0, 0, 0, 85, 2, 1, 0};
    tbl[9]  = '{1, 0, 0, 0, 0, 90, 2, 1, 0};
    tbl[10] = '{1, 0, 0, 0, 0, 95, 2, 1, 0};
    tbl[11] = '{1, 0, 0, 0, 0, 95, 2, 1, 1};
    tbl[12] = '{0, 0, 1, 0, 1, 90, 5, 0, 1};

    // Reset state
    tick();
    rst = 0;
    chk("reset_outs", outs(), 0);

    for (int i = 0; i < 13; i++) begin
      pulse(tbl[i].n, tbl[i].d, tbl[i].q, tbl[i].s, tbl[i].c);
      chk($sformatf("tbl%0d", i), int'({credit, state, purchase_ready, coin_reject}),
          int'({7'(tbl[i].credit), 3'(tbl[i].st), tbl[i].rdy, tbl[i].rej}));
    end
    drain("tbl_drain");

    // Three quarters four cycles apart
    pulse(0, 0, 1, 0, 0); chk("q1_credit", credit, 25); repeat (3) tick();
    pulse(0, 0, 1, 0, 0); chk("q2_credit", credit, 50); repeat (3) tick();
    pulse(0, 0, 1, 0, 0); chk("q3_credit", credit, 75);
    chk("q3_ready_state", {purchase_ready, state}, 4'h2 | 4'h8);

    // Exact-price purchase
    pulse(0, 0, 0, 1, 0);
    chk("sel75_first", {28'd0, dispense, busy, state}, {28'd0, 1'b1, 1'b1, 3'd3});
    chk("sel75_credit", credit, 0);
    scan(dcnt, ncnt, first_n, gap_ok);
    chk("sel75_disp_cycles", dcnt, DCYC);
    chk("sel75_nickels", ncnt, 0);
    chk("sel75_end", {state, credit}, 0);

    // Purchase at 85 leaves 10
    pulse(0, 0, 1, 0, 0); pulse(0, 0, 1, 0, 0); pulse(0, 0, 1, 0, 0); pulse(0, 1, 0, 0, 0);
    chk("c85_credit", credit, 85);
    pulse(0, 0, 0, 1, 0);
    chk("c85_reduced", credit, 10);
    scan(dcnt, ncnt, first_n, gap_ok);
    chk("c85_disp_cycles", dcnt, DCYC);
`ifdef VEND_CHANGE_RETURN_EN
    chk("c85_nickels", ncnt, 2);
    chk("c85_first_nickel", first_n, DCYC);
    chk("c85_gap", gap_ok, 1);
    chk("c85_end", {state, credit}, 0);
`else
    chk("c85_nickels", ncnt, 0);
    chk("c85_end", {state, credit}, {3'd1, 7'd10});
`endif
    drain("c85_drain");

    // Cancel at 15: first nickel the very next cycle
    pulse(0, 1, 0, 0, 0); pulse(1, 0, 0, 0, 0);
    chk("c15_credit", credit, 15);
    pulse(0, 0, 0, 0, 1);
    chk("c15_first", {change_nickel, busy, state}, {1'b1, 1'b1, 3'd5});
    scan(dcnt, ncnt, first_n, gap_ok);
    chk("c15_nickels", ncnt, 3);
    chk("c15_gap", gap_ok, 1);
    chk("c15_end", {state, credit}, 0);

    // Overflow refusal at 90, then cancel beats select and coin
    pulse(0, 0, 1, 0, 0); pulse(0, 0, 1, 0, 0); pulse(0, 0, 1, 0, 0);
    pulse(0, 1, 0, 0, 0); pulse(1, 0, 0, 0, 0);
    pulse(0, 0, 1, 0, 0);
    chk("ovf_reject", {coin_reject, credit}, {1'b1, 7'd90});
    tick();
    chk("ovf_reject_once", coin_reject, 0);
    pulse(0, 0, 1, 1, 1);
    chk("cancel_wins", {dispense, coin_reject, state, credit}, {1'b0, 1'b1, 3'd5, 7'd85});
    drain("ovf_drain");

    // Two coins from zero: quarter taken, one reject
    pulse(1, 0, 1, 0, 0);
    chk("dual_coin", {coin_reject, credit}, {1'b1, 7'd25});
    tick();
    chk("dual_reject_once", coin_reject, 0);
    drain("dual_drain");

    // Reset on the second dispense cycle
    pulse(0, 0, 1, 0, 0); pulse(0, 0, 1, 0, 0); pulse(0, 0, 1, 0, 0);
    pulse(0, 0, 0, 1, 0);
    tick();
    chk("rst_mid_disp_pre", {dispense, state}, {1'b1, 3'd3});
    rst = 1;
    tick();
    rst = 0;
    chk("rst_mid_disp", outs(), 0);

    // Randomized run against the reference model
    rst = 1;
    model_step(1, 0, 0, 0, 0, 0);
    tick();
    rst = 0;
    for (int i = 0; i < 3000; i++) begin
      rn = ($urandom_range(0, 5) == 0);
      rd = ($urandom_range(0, 5) == 0);
      rq = ($urandom_range(0, 4) == 0);
      rs = ($urandom_range(0, 4) == 0);
      rc = ($urandom_range(0, 15) == 0);
      rr = ($urandom_range(0, 299) == 0);
      coin_nickel = rn; coin_dime = rd; coin_quarter = rq;
      btn_select = rs; btn_cancel = rc; rst = rr;
      model_step(rr, rn, rd, rq, rs, rc);
      tick();
      chk($sformatf("rand%0d", i), outs(), model_outs());
    end
    coin_nickel = 0; coin_dime = 0; coin_quarter = 0;
    btn_select = 0; btn_cancel = 0; rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vend_sequencer.md
# vend_sequencer

Transaction controller for the Basys 3 vending machine: consumes debounced one-shot coin and button pulses, keeps running credit, and sequences the purchase, dispense and change-return datapath. Sits between the `debounce_one_shot` instances and `state_decoder`, exporting its state code for LED display.

## Interface
Parameters:
- `PRICE_CENTS`, 75: item price, a multiple of 5.
- `MAX_CREDIT`, 95: highest credit accepted, a multiple of 5 and less than 128.
- `DISPENSE_CYCLES`, 4: cycles `dispense` is held high, at least 1.
- `CHANGE_GAP`, 2: low cycles between `change_nickel` pulses, at least 1.

Ports:
- `clk`, in, 1: system clock. One clock domain.
- `rst`, in, 1: synchronous, active-high reset.
- `coin_nickel`, in, 1: one-cycle pulse worth 5.
- `coin_dime`, in, 1: one-cycle pulse worth 10.
- `coin_quarter`, in, 1: one-cycle pulse worth 25.
- `btn_select`, in, 1: one-cycle pulse requesting a purchase.
- `btn_cancel`, in, 1: one-cycle pulse requesting a refund.
- `credit`, out, 7: current credit in cents.
- `state`, out, 3: state code for `state_decoder`.
- `purchase_ready`, out, 1: high when `credit >= PRICE_CENTS` and the block is idle-capable.
- `dispense`, out, 1: dispense strobe.
- `change_nickel`, out, 1: one-cycle pulse per nickel returned.
- `coin_reject`, out, 1: one-cycle pulse when a coin is refused.
- `busy`, out, 1: high in DISPENSE, CHANGE and REFUND.

## Operation
State codes:
- IDLE=0: credit is 0.
- CREDIT=1: 0 < credit < PRICE_CENTS.
- READY=2: credit >= PRICE_CENTS.
- DISPENSE=3.
- CHANGE=4.
- REFUND=5.
- Codes 6 and 7 are illegal and go to IDLE on the next cycle.

Coin acceptance (IDLE, CREDIT, READY only):
- Simultaneous coin pulses are resolved by priority: quarter, then dime, then nickel. Only one coin is accepted.
- Any dropped coin pulses assert `coin_reject`.
- If `credit + value > MAX_CREDIT`, the coin is rejected and credit is unchanged.
- Any coin pulse seen in DISPENSE, CHANGE or REFUND is rejected.

Select:
- Acted on in READY only. Ignored in every other state.
- READY goes to DISPENSE, and credit is reduced by PRICE_CENTS on that transition.

Cancel:
- Acted on in CREDIT and READY, and goes to REFUND.
- Ignored in IDLE and while `busy` is high.
- If cancel and select arrive in the same cycle, cancel wins.
- If a coin and cancel arrive in the same cycle, the coin is rejected and cancel wins.

DISPENSE exit, after DISPENSE_CYCLES:
- With the configuration macro defined and credit > 0: go to CHANGE.
- Otherwise: go to IDLE, CREDIT or READY according to the remaining credit.

CHANGE and REFUND:
- Pulse `change_nickel` and subtract 5 in the same cycle.
- Then hold `change_nickel` low for CHANGE_GAP cycles.
- Repeat until credit is 0, then go to IDLE.

Arithmetic:
- Credit is 7-bit unsigned, always a multiple of 5, and never exceeds MAX_CREDIT.
- Credit never underflows.

## Timing
- Reset: `credit`=0, `state`=IDLE, and every 1-bit output is 0 on the cycle after `rst` is sampled high.
- Reset mid-DISPENSE, mid-CHANGE or mid-REFUND aborts the transaction. Credit is lost.
- All outputs are registered.
- Coin accepted at cycle N: `credit`, `state` and `purchase_ready` are updated at N+1.
- `coin_reject` is high at N+1 for exactly 1 cycle.
- Select at N: `dispense` is high for cycles N+1 through N+DISPENSE_CYCLES, and the reduced credit is visible at N+1.
- First `change_nickel` pulse:
  - After DISPENSE: on the cycle after `dispense` falls.
  - For cancel at N: at N+1.
- Change pulse period is 1+CHANGE_GAP cycles.
- `busy` is high from the cycle the block enters DISPENSE or REFUND until the cycle it returns to IDLE, CREDIT or READY.

## Configuration
- `VEND_CHANGE_RETURN_EN` defined: leftover credit after dispense is returned through CHANGE.
- Undefined:
  - Leftover credit is carried over for the next purchase.
  - The CHANGE state is never entered, and its code is treated as illegal.
  - REFUND on cancel is present in both builds.

## Structure
- Package `vend_pkg` holds:
  - `vend_state_t`, the enum of 3-bit state codes.
  - Constants `NICKEL_C`=5, `DIME_C`=10, `QUARTER_C`=25 and `CREDIT_W`=7.
- One sub-module, `vend_pulse_timer`: a loadable down-counter with a `done` flag. It is shared for dispense hold and change gap, and is never needed for both at once.

## Test plan
- Reset, then 3 quarter pulses 4 cycles apart:
  - `credit` reads 25, 50, 75.
  - `purchase_ready`=1 and `state`=2 after the third pulse.
- At credit 75, pulse select:
  - `dispense` high for 4 cycles and `credit`=0.
  - Then IDLE, with no `change_nickel` pulses.
- At credit 85, pulse select, macro on:
  - 4 dispense cycles, then 2 `change_nickel` pulses 3 cycles apart.
  - Ends in IDLE with credit 0.
- Same stimulus, macro off: ends in CREDIT with credit 10.
- Credit 15 (dime then nickel), pulse cancel: 3 `change_nickel` pulses, then IDLE.
- Credit 90, pulse quarter: `coin_reject` pulse and credit stays 90.
- From credit 0, nickel and quarter in the same cycle: credit 25 and one `coin_reject` pulse.
- Assert `rst` on the second cycle of DISPENSE: next cycle `state`=0, `credit`=0, and every 1-bit output is 0.
